// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer for the E stage; results land in HI/LO after a fixed latency.
// Optional MDU_FLUSH_EN macro adds a flush input that cancels an in-flight operation.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [31:0] pending_hi;
    logic [31:0] pending_lo;

    logic        signed_op;
    logic        md_class;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        signed_op = (md_op == OP_MULT) || (md_op == OP_DIV);
        md_class  = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                    (md_op == OP_DIV)  || (md_op == OP_DIVU);
        a_ext     = {{32{signed_op & a[31]}}, a};
        b_ext     = {{32{signed_op & b[31]}}, b};
        prod      = a_ext * b_ext;
        a_neg     = signed_op & a[31];
        b_neg     = signed_op & b[31];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        q_mag     = a_mag / b_mag;
        r_mag     = a_mag % b_mag;
        quo       = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem       = a_neg ? -r_mag : r_mag;
    end

    assign stall_req = d_md & (busy | (start & md_class));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
        end
`ifdef MDU_FLUSH_EN
        else if (flush) begin
            state      <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            pending_hi <= '0;
            pending_lo <= '0;
        end
`endif
        else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                pending_hi <= prod[63:32];
                                pending_lo <= prod[31:0];
                                count      <= 4'(MULT_CYCLES);
                                state      <= MUL;
                                busy       <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                // Divide by zero commits the current HI/LO back, leaving them unchanged.
                                pending_hi <= (b == '0) ? hi : rem;
                                pending_lo <= (b == '0) ? lo : quo;
                                count      <= 4'(DIV_CYCLES);
                                state      <= DIV;
                                busy       <= 1'b1;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        hi    <= pending_hi;
                        lo    <= pending_lo;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios with literal expectations plus random traffic
// compared every cycle against a timestamp-based behavioural model of HI/LO, busy and stall_req.
module tb_mdu_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_md;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    int errors = 0;
    int checks = 0;

    mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .a         (a),
        .b         (b),
        .d_md      (d_md),
`ifdef MDU_FLUSH_EN
        .flush     (flush),
`endif
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: an accepted op is a timestamp done_at; busy while the edge count is below it,
    // and the pre-computed pair is written to HI/LO on the edge that reaches it.
    int          cyc = 0;
    int          done_at = -1;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    logic        chk_en = 1'b0;

    function automatic logic m_busy();
        return done_at > cyc;
    endfunction

    task automatic model_result(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        p = 0; q = 0; r = 0;
        case (op)
            3'd1: p = sx * sy;
            3'd2: p = ux * uy;
            3'd3: if (y != 0) begin q = sx / sy; r = sx % sy; end
            3'd4: if (y != 0) begin q = ux / uy; r = ux % uy; end
            default: ;
        endcase
        if (op <= 3'd2) begin
            p_hi = p[63:32];
            p_lo = p[31:0];
        end else if (y == 0) begin
            p_hi = m_hi;
            p_lo = m_lo;
        end else begin
            p_hi = r[31:0];
            p_lo = q[31:0];
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; done_at = -1;
        end else if (flush) begin
            done_at = -1;
        end else if (done_at == cyc) begin
            m_hi = p_hi;
            m_lo = p_lo;
        end else if (!m_busy() && start) begin
            case (md_op)
                3'd1, 3'd2: begin model_result(md_op, a, b); done_at = cyc + MULT_CYCLES; end
                3'd3, 3'd4: begin model_result(md_op, a, b); done_at = cyc + DIV_CYCLES; end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("busy", 32'(busy), 32'(m_busy()));
            check("stall_req", 32'(stall_req),
                  32'(d_md & (m_busy() | (start & (md_op >= 3'd1) & (md_op <= 3'd4)))));
        end
    end

    // Issue one md op and count busy cycles; called #1 after a rising edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic dm, input int k);
        int n;
        start = 1'b1; md_op = op; a = x; b = y; d_md = dm;
        #1;
        if (dm) check("stall_on_start", 32'(stall_req), 32'd1);
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (dm) check("stall_while_busy", 32'(stall_req), 32'd1);
            n++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 32'(n), 32'(k));
        if (dm) check("stall_after_commit", 32'(stall_req), 32'd0);
        d_md = 1'b0;
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] x);
        start = 1'b1; md_op = op; a = x; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        check("mt_no_busy", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 3'd0; a = '0; b = '0; d_md = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, MULT_CYCLES);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        run_op(3'd4, 32'd7, 32'hFFFF_FFFF, 1'b0, DIV_CYCLES);
        check("divu_lo", lo, 32'h0);
        check("divu_hi", hi, 32'h7);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, DIV_CYCLES);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DIV_CYCLES);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0);

        move_to(3'd5, 32'h1234);
        move_to(3'd6, 32'h5678);
        run_op(3'd3, 32'd99, 32'd0, 1'b0, DIV_CYCLES);
        check("div0_hi", hi, 32'h1234);
        check("div0_lo", lo, 32'h5678);

        run_op(3'd1, 32'd6, 32'd7, 1'b1, MULT_CYCLES);
        check("stall_mult_lo", lo, 32'd42);
        start = 1'b1; md_op = 3'd5; a = 32'hABCD; d_md = 1'b1;
        #1;
        check("stall_mthi", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0; d_md = 1'b0;
        check("mthi_hi", hi, 32'hABCD);

        start = 1'b1; md_op = 3'd1; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        run_op(3'd1, 32'd5, 32'd6, 1'b0, MULT_CYCLES);
        check("after_rst_lo", lo, 32'd30);

`ifdef MDU_FLUSH_EN
        move_to(3'd5, 32'h11);
        move_to(3'd6, 32'h22);
        start = 1'b1; md_op = 3'd2; a = 32'h1_0000; b = 32'h1_0000;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        repeat (6) begin @(posedge clk); #1; end
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h22);
`endif

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            d_md  = $urandom_range(0, 1);
`ifdef MDU_FLUSH_EN
            flush = ($urandom_range(0, 49) == 0);
`endif
            if (!m_busy() && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                md_op = 3'($urandom_range(0, 7));
                a     = rand_val();
                b     = rand_val();
            end else begin
                start = 1'b0;
                md_op = 3'($urandom_range(0, 7));
                a     = $urandom;
                b     = $urandom;
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; start = 1'b0; flush = 1'b0; d_md = 1'b0;
        repeat (12) begin @(posedge clk); #1; end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
